sram_like_resp: RTL

//   Responder (slave) end of the sram-like req/addr_ok/data_ok interface driven by cpu_core's

---
 rtl/sram_like_resp.sv | 90 +++++++++
 1 files changed

// File: rtl/sram_like_resp.sv
// rtl/sram_like_resp.sv - sram-like req/addr_ok/data_ok responder with word memory and fixed-latency in-order responses
module sram_like_resp #(
    parameter int AW      = 10,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    input  logic        hold
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int CW   = $clog2(LATENCY) + 3;
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);

    logic [31:0]     mem [2**AW];
    logic            q_wr   [DEPTH];
    logic [31:0]     q_data [DEPTH];
    logic [CW-1:0]   q_due  [DEPTH];

    logic [CNTW-1:0] count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   now;

    logic [AW-1:0]   widx;
    logic            accept;
    logic            retire;
    logic [CW-1:0]   head_age;
    logic            unused_bits;

    assign widx        = addr[AW+1:2];
    assign addr_ok     = !reset && (count < FULL);
    assign accept      = req && addr_ok;
    // Wrap-safe due test: the MSB of (now - due) is the sign of the wait.
    assign head_age    = now - q_due[rd_ptr];
    assign retire      = (count != '0) && !head_age[CW-1] && !hold;
    assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            now     <= '0;
            data_ok <= 1'b0;
            rdata   <= '0;
        end else begin
            now     <= now + 1'b1;
            data_ok <= retire;
            rdata   <= (retire && !q_wr[rd_ptr]) ? q_data[rd_ptr] : 32'h0;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (retire) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Memory and queue payload are never reset; a reset only invalidates via count/pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_wr[wr_ptr]   <= wr;
            q_data[wr_ptr] <= wr ? 32'h0 : mem[widx];
            q_due[wr_ptr]  <= now + CW'(LATENCY);
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // A head entry held past half the counter range would look "not yet due" forever.
    assert property (@(posedge clk) disable iff (reset)
        (count != '0) |-> (int'($signed(head_age)) >= -LATENCY));

endmodule
